// File: rtl/clock_reset_sequencer.sv
// rtl/clock_reset_sequencer.sv - lock-qualified reset sequencer with staggered channel release
// and per-channel divided clock-enables.
module clock_reset_sequencer #(
    parameter int N_LOCK      = 1,
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int LOSS_FILTER = 3
) (
    input  logic                    system_clock_buffered,
    input  logic                    reset,
    input  logic [N_LOCK-1:0]       locked_in,
    input  logic [N_CH*DIV_W-1:0]   div_value,
    input  logic [N_CH-1:0]         ch_enable_mask,
    output logic                    sys_reset_out,
    output logic [N_CH-1:0]         ch_reset,
    output logic [N_CH-1:0]         ce,
    output logic                    all_ready,
    output logic [7:0]              lock_lost_count
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int LW = $clog2(LOSS_FILTER + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_RELEASE, S_RUN} state_t;

    state_t             r_state, w_state_next;
    logic [HW-1:0]      r_hold_cnt, w_hold_cnt_next;
    logic [SW-1:0]      r_stg_cnt, w_stg_cnt_next;
    logic [LW-1:0]      r_loss_cnt, w_loss_cnt_next;
    logic               r_sys_reset, w_sys_reset_next;
    logic [N_CH-1:0]    r_ch_reset, w_ch_reset_next;
    logic               r_all_ready, w_all_ready_next;
    logic [7:0]         r_lost_count;
    logic [N_CH-1:0]    r_ce;
    logic [DIV_W-1:0]   r_div_cnt [N_CH];
    logic [DIV_W-1:0]   w_div [N_CH];
    logic               w_all_locked;
    logic               w_loss_event;
    logic               w_step;

    assign w_all_locked    = &locked_in;
    assign sys_reset_out   = r_sys_reset;
    assign ch_reset        = r_ch_reset;
    assign ce              = r_ce;
    assign all_ready       = r_all_ready;
    assign lock_lost_count = r_lost_count;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_div[i] = div_value[i*DIV_W +: DIV_W];
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_hold_cnt_next  = r_hold_cnt;
        w_stg_cnt_next   = r_stg_cnt;
        w_loss_cnt_next  = '0;
        w_sys_reset_next = r_sys_reset;
        w_ch_reset_next  = r_ch_reset;
        w_all_ready_next = r_all_ready;
        w_loss_event     = 1'b0;
        w_step           = 1'b0;
        case (r_state)
            S_HOLD: begin
                w_sys_reset_next = 1'b1;
                w_ch_reset_next  = '1;
                w_all_ready_next = 1'b0;
                w_hold_cnt_next  = '0;
                w_stg_cnt_next   = '0;
                if (w_all_locked) begin
                    w_state_next = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (!w_all_locked) begin
                    w_state_next    = S_HOLD;
                    w_hold_cnt_next = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_sys_reset_next = 1'b0;
                    w_hold_cnt_next  = '0;
                    w_stg_cnt_next   = '0;
                    w_step           = 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                // RELEASE and RUN share the filtered lock-loss watch
                if (!w_all_locked && r_loss_cnt == LOSS_LAST) begin
                    w_loss_event     = 1'b1;
                    w_state_next     = S_HOLD;
                    w_sys_reset_next = 1'b1;
                    w_ch_reset_next  = '1;
                    w_all_ready_next = 1'b0;
                    w_stg_cnt_next   = '0;
                end else begin
                    w_loss_cnt_next = w_all_locked ? '0 : r_loss_cnt + LW'(1);
                    if (r_state == S_RELEASE) begin
                        if (r_stg_cnt == STG_LAST) begin
                            w_stg_cnt_next = '0;
                            w_step         = 1'b1;
                        end else begin
                            w_stg_cnt_next = r_stg_cnt + SW'(1);
                        end
                    end
                end
            end
        endcase
        // Channels release lowest-first, so a left shift frees the next one
        if (w_step) begin
            w_ch_reset_next = r_ch_reset << 1;
            if (w_ch_reset_next == '0) begin
                w_state_next     = S_RUN;
                w_all_ready_next = 1'b1;
            end else begin
                w_state_next = S_RELEASE;
            end
        end
    end

    always_ff @(posedge system_clock_buffered) begin
        if (reset) begin
            r_state      <= S_HOLD;
            r_hold_cnt   <= '0;
            r_stg_cnt    <= '0;
            r_loss_cnt   <= '0;
            r_sys_reset  <= 1'b1;
            r_ch_reset   <= '1;
            r_all_ready  <= 1'b0;
            r_lost_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_stg_cnt   <= w_stg_cnt_next;
            r_loss_cnt  <= w_loss_cnt_next;
            r_sys_reset <= w_sys_reset_next;
            r_ch_reset  <= w_ch_reset_next;
            r_all_ready <= w_all_ready_next;
            if (w_loss_event && r_lost_count != 8'hFF) begin
                r_lost_count <= r_lost_count + 8'd1;
            end
        end
    end

    // Dividers key off the next reset value so d=0 pulses in the first released cycle
    always_ff @(posedge system_clock_buffered) begin
        for (int i = 0; i < N_CH; i++) begin
            if (reset || w_ch_reset_next[i] || !ch_enable_mask[i]) begin
                r_div_cnt[i] <= '0;
                r_ce[i]      <= 1'b0;
            end else if (r_div_cnt[i] == w_div[i]) begin
                r_div_cnt[i] <= '0;
                r_ce[i]      <= 1'b1;
            end else if (r_div_cnt[i] > w_div[i]) begin
                r_div_cnt[i] <= '0;
                r_ce[i]      <= 1'b0;
            end else begin
                r_div_cnt[i] <= r_div_cnt[i] + DIV_W'(1);
                r_ce[i]      <= 1'b0;
            end
        end
    end

endmodule
